// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   state_t : supervisor sequencing states
//   cnt_w() : counter width for a terminal count, never narrower than 1 bit
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1; a 1-bit floor keeps degenerate
  // parameter choices from producing zero-width vectors.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, loads RESET_VAL into both flops
//   d       : asynchronous input
//   q       : synchronised output, two clk edges of latency
module bit_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the CSI-2 clock-doubler PLL: timed RST pulse, LOCK glitch
// filter, lock timeout with bounded retries, and restart on loss of lock.
// Runs on the free-running PLL reference clock.
//   clk          : PLL reference clock
//   reset_n      : asynchronous active-low reset
//   pll_lock     : raw PLL LOCK (asynchronous)
//   soft_restart : one-cycle request to restart the sequence
//   pll_rst      : PLL RST, active high
//   sys_rst_n    : downstream reset, released only while locked
//   locked       : qualified lock status
//   fail         : retries exhausted, supervisor parked
//   retry_cnt    : retries consumed in the current sequence
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_FILTER_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 7,
  localparam int RETRY_W         = cnt_w(MAX_RETRY + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_lock,
  input  logic               soft_restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  // Pulse counter must reach RST_PULSE_CYC itself (see entry value below).
  localparam int RST_W = cnt_w(RST_PULSE_CYC + 1);
  localparam int FLT_W = cnt_w(LOCK_FILTER_CYC);
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT_CYC);

  state_t             state, state_nx;
  logic [RST_W-1:0]   rst_cnt, rst_cnt_nx;
  logic [FLT_W-1:0]   flt_cnt, flt_cnt_nx;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nx;
  logic [RETRY_W-1:0] retry_nx;
  logic               lock_s;

  bit_sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  // The pulse counter is loaded with 1 when RESET_PLL is entered from another
  // state, because the entry edge itself is the first high cycle. Out of
  // reset it starts at 0, so the pulse spans RST_PULSE_CYC edges after
  // reset_n is released.
  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    flt_cnt_nx = flt_cnt;
    tmo_cnt_nx = tmo_cnt;
    retry_nx   = retry_cnt;
    if (soft_restart) begin
      state_nx   = RESET_PLL;
      rst_cnt_nx = RST_W'(1);
      retry_nx   = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (rst_cnt == RST_W'(RST_PULSE_CYC)) begin
            state_nx   = WAIT_LOCK;
            tmo_cnt_nx = '0;
          end else begin
            rst_cnt_nx = rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK, FILTER: begin
          // Timeout spans both states and is not reset by filter drops.
          if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYC - 1)) begin
            if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
              state_nx = FAIL;
            end else begin
              state_nx   = RESET_PLL;
              rst_cnt_nx = RST_W'(1);
              retry_nx   = retry_cnt + 1'b1;
            end
          end else begin
            tmo_cnt_nx = tmo_cnt + 1'b1;
            if (state == WAIT_LOCK) begin
              if (lock_s) begin
                state_nx   = FILTER;
                flt_cnt_nx = '0;
              end
            end else if (!lock_s) begin
              state_nx = WAIT_LOCK;
            end else if (flt_cnt == FLT_W'(LOCK_FILTER_CYC - 1)) begin
              state_nx = RUN;
              retry_nx = '0;
            end else begin
              flt_cnt_nx = flt_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nx   = RESET_PLL;
            rst_cnt_nx = RST_W'(1);
          end
        end
        FAIL:    state_nx = FAIL;
        default: begin
          state_nx   = RESET_PLL;
          rst_cnt_nx = RST_W'(1);
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // the state is entered, straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_PLL;
      rst_cnt   <= '0;
      flt_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nx;
      rst_cnt   <= rst_cnt_nx;
      flt_cnt   <= flt_cnt_nx;
      tmo_cnt   <= tmo_cnt_nx;
      retry_cnt <= retry_nx;
      pll_rst   <= (state_nx == RESET_PLL) || (state_nx == FAIL);
      sys_rst_n <= (state_nx == RUN);
      locked    <= (state_nx == RUN);
      fail      <= (state_nx == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters
// (pulse 4, filter 8, timeout 64, two retries). Edge 0 is the first rising
// clk edge after reset_n is released; inputs change 1 time unit after an
// edge and outputs are sampled at that same point.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset_n;
  logic       pll_lock;
  logic       soft_restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [1:0] retry_cnt;

  int n_chk;
  int n_fail;
  int edge_n;

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (4),
    .LOCK_FILTER_CYC  (8),
    .LOCK_TIMEOUT_CYC (64),
    .MAX_RETRY        (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_lock     (pll_lock),
    .soft_restart (soft_restart),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .locked       (locked),
    .fail         (fail),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic go_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  // Reset with the given lock level; the next rising edge is edge 0.
  task automatic do_reset(input logic lock);
    reset_n      = 1'b0;
    soft_restart = 1'b0;
    pll_lock     = lock;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    edge_n  = -1;
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    edge_n       = -1;
    reset_n      = 1'b0;
    soft_restart = 1'b0;
    pll_lock     = 1'b1;

    // Clean lock from time 0, then loss of lock in RUN, then async reset.
    do_reset(1'b1);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_cnt, 0);
    go_to(3);  chk("s1_pll_rst_e3", pll_rst, 1);
    go_to(4);  chk("s1_pll_rst_e4", pll_rst, 0);
    go_to(12); chk("s1_sys_e12", sys_rst_n, 0);
    go_to(13); chk("s1_sys_e13", sys_rst_n, 1);
    chk("s1_locked_e13", locked, 1);
    go_to(20); pll_lock = 1'b0;
    go_to(22); chk("s4_sys_e22", sys_rst_n, 1);
    go_to(23); chk("s4_sys_e23", sys_rst_n, 0);
    chk("s4_locked_e23", locked, 0);
    chk("s4_pll_rst_e23", pll_rst, 1);
    chk("s4_retry_e23", retry_cnt, 0);
    pll_lock = 1'b1;
    go_to(26); chk("s4_pll_rst_e26", pll_rst, 1);
    go_to(27); chk("s4_pll_rst_e27", pll_rst, 0);
    go_to(35); chk("s4_sys_e35", sys_rst_n, 0);
    go_to(36); chk("s4_sys_e36", sys_rst_n, 1);
    chk("s4_retry_e36", retry_cnt, 0);
    go_to(40);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys", sys_rst_n, 0);
    chk("async_locked", locked, 0);

    // One-cycle lock glitch during FILTER: back to WAIT_LOCK, RUN later.
    do_reset(1'b1);
    go_to(8);  pll_lock = 1'b0;
    go_to(9);  pll_lock = 1'b1;
    go_to(13); chk("s3a_sys_e13", sys_rst_n, 0);
    go_to(19); chk("s3a_sys_e19", sys_rst_n, 0);
    go_to(20); chk("s3a_sys_e20", sys_rst_n, 1);

    // Long drop: timeout not cleared by the drop, one retry, then RUN.
    do_reset(1'b1);
    go_to(8);  pll_lock = 1'b0;
    go_to(59); pll_lock = 1'b1;
    go_to(67); chk("s3b_pll_rst_e67", pll_rst, 0);
    chk("s3b_retry_e67", retry_cnt, 0);
    go_to(68); chk("s3b_pll_rst_e68", pll_rst, 1);
    chk("s3b_retry_e68", retry_cnt, 1);
    go_to(72); chk("s3b_pll_rst_e72", pll_rst, 0);
    go_to(80); chk("s3b_sys_e80", sys_rst_n, 0);
    chk("s3b_retry_e80", retry_cnt, 1);
    go_to(81); chk("s3b_sys_e81", sys_rst_n, 1);
    chk("s3b_retry_e81", retry_cnt, 0);

    // No lock at all: three pulses, then FAIL; soft restarts.
    do_reset(1'b0);
    go_to(3);   chk("s2_pll_rst_e3", pll_rst, 1);
    go_to(4);   chk("s2_pll_rst_e4", pll_rst, 0);
    go_to(67);  chk("s2_pll_rst_e67", pll_rst, 0);
    go_to(68);  chk("s2_pll_rst_e68", pll_rst, 1);
    chk("s2_retry_e68", retry_cnt, 1);
    go_to(71);  chk("s2_pll_rst_e71", pll_rst, 1);
    go_to(72);  chk("s2_pll_rst_e72", pll_rst, 0);
    go_to(135); chk("s2_pll_rst_e135", pll_rst, 0);
    go_to(136); chk("s2_pll_rst_e136", pll_rst, 1);
    chk("s2_retry_e136", retry_cnt, 2);
    go_to(203); chk("s2_fail_e203", fail, 0);
    chk("s2_pll_rst_e203", pll_rst, 0);
    go_to(204); chk("s2_fail_e204", fail, 1);
    chk("s2_pll_rst_e204", pll_rst, 1);
    chk("s2_retry_e204", retry_cnt, 2);
    chk("s2_sys_e204", sys_rst_n, 0);
    go_to(250); chk("s2_fail_e250", fail, 1);
    chk("s2_pll_rst_e250", pll_rst, 1);
    chk("s2_retry_e250", retry_cnt, 2);
    go_to(259); soft_restart = 1'b1;
    go_to(260); soft_restart = 1'b0;
    chk("s5_fail_e260", fail, 0);
    chk("s5_retry_e260", retry_cnt, 0);
    chk("s5_pll_rst_e260", pll_rst, 1);
    go_to(263); chk("s5_pll_rst_e263", pll_rst, 1);
    go_to(264); chk("s5_pll_rst_e264", pll_rst, 0);
    go_to(327); soft_restart = 1'b1;
    go_to(328); soft_restart = 1'b0;
    chk("s5_pll_rst_e328", pll_rst, 1);
    chk("s5_retry_e328", retry_cnt, 0);
    chk("s5_fail_e328", fail, 0);
    go_to(332); chk("s5_pll_rst_e332", pll_rst, 0);
    go_to(395); chk("s5_retry_e395", retry_cnt, 0);
    go_to(396); chk("s5_pll_rst_e396", pll_rst, 1);
    chk("s5_retry_e396", retry_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
